// File: rtl/sense_trace_writer_pkg.sv
// -----------------------------------------------------------------------------
// sense_trace_writer_pkg
//   Shared types and default constants for the sensor-trace write path.
//   - sense_state_t : acquisition FSM state encoding
//   - DEF_*         : default geometry (512x8 BRAM, 7-bit coded samples,
//                     56 samples per trigger, 8-bit delay, 8-deep pre-trigger ring)
//   - state_is_busy : states in which an acquisition is in progress
// -----------------------------------------------------------------------------
package sense_trace_writer_pkg;

  localparam int DEF_AW      = 9;
  localparam int DEF_SW      = 7;
  localparam int DEF_NSAMP   = 56;
  localparam int DEF_DLYW    = 8;
  localparam int DEF_PRETRIG = 8;

  // BRAM data port width; coded samples are zero-extended up to this.
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } sense_state_t;

  function automatic logic state_is_busy(input sense_state_t s);
    return (s == ST_ARMED) || (s == ST_DELAY) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/sense_trace_writer_if.sv
// -----------------------------------------------------------------------------
// sense_trace_writer_if
//   Control / sample / BRAM-write bundle of the sensor-trace writer.
//   master : controller side (drives arm, trig, trig_delay, sample_in,
//            sample_valid; observes we, waddr, wdata, busy, done, start_addr)
//   slave  : the trace writer itself
//   Parameters: AW (BRAM address width), SW (coded sample width),
//               DLYW (trigger delay width)
// -----------------------------------------------------------------------------
interface sense_trace_writer_if
  import sense_trace_writer_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int SW   = DEF_SW,
  parameter int DLYW = DEF_DLYW
);

  logic              arm;
  logic              trig;
  logic [DLYW-1:0]   trig_delay;
  logic [SW-1:0]     sample_in;
  logic              sample_valid;

  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [AW-1:0]     start_addr;

  modport master (
    output arm, trig, trig_delay, sample_in, sample_valid,
    input  we, waddr, wdata, busy, done, start_addr
  );

  modport slave (
    input  arm, trig, trig_delay, sample_in, sample_valid,
    output we, waddr, wdata, busy, done, start_addr
  );

endinterface

// File: rtl/sense_trace_writer_edge_det.sv
// -----------------------------------------------------------------------------
// sense_edge_det
//   Rising-edge detector: the input is registered every cycle and the edge is
//   the current level high while the previous sample was low. Reusable for
//   any level-type event flag (AES round trigger, aes_done, ...).
//   Ports:
//     clk    in  clock
//     rst    in  asynchronous active-high reset (clears the history to 0)
//     i_sig  in  level to watch
//     o_rise out i_sig & ~previous i_sig
// -----------------------------------------------------------------------------
module sense_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/sense_trace_writer.sv
// -----------------------------------------------------------------------------
// sense_trace_writer
//   Write side of the sensor-trace BRAM. An arm pulse readies the block; the
//   next rising edge of trig (optionally followed by trig_delay clock cycles)
//   starts a capture of NSAMP valid decoded samples into the BRAM write port.
//   Ports:
//     clk  in  sample clock (BRAM write clock)
//     rst  in  asynchronous active-high reset
//     bus  sense_trace_writer_if.slave
//          arm/trig/trig_delay/sample_in/sample_valid in,
//          we/waddr/wdata (registered BRAM write port), busy, done,
//          start_addr (oldest stored sample, valid while done) out
//   Build option SENSE_PRETRIG_EN: while armed, valid samples are kept in a
//   PRETRIG-deep ring at addresses 0..PRETRIG-1 and the capture lands at
//   PRETRIG..PRETRIG+NSAMP-1. Without it nothing is written while armed,
//   capture lands at 0..NSAMP-1 and start_addr is 0.
// -----------------------------------------------------------------------------
module sense_trace_writer
  import sense_trace_writer_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int SW      = DEF_SW,
  parameter int NSAMP   = DEF_NSAMP,
  parameter int DLYW    = DEF_DLYW,
  parameter int PRETRIG = DEF_PRETRIG
) (
  input  logic                clk,
  input  logic                rst,
  sense_trace_writer_if.slave bus
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSAMP - 1);

`ifdef SENSE_PRETRIG_EN
  localparam logic [AW-1:0] CAP_BASE  = AW'(PRETRIG);
  localparam logic [AW-1:0] RING_LAST = AW'(PRETRIG - 1);
  localparam logic [CW-1:0] RING_FULL = CW'(PRETRIG);
`else
  localparam logic [AW-1:0] CAP_BASE  = '0;
`endif

  sense_state_t      r_state, w_state_next;
  logic [DLYW-1:0]   r_dly_cnt, w_dly_cnt_next;
  logic [CW-1:0]     r_cnt, w_cnt_next;
  logic [AW-1:0]     r_ptr, w_ptr_next;
  logic              r_we, w_we_next;
  logic [AW-1:0]     r_waddr, w_waddr_next;
  logic [DATA_W-1:0] r_wdata, w_wdata_next;
  logic              r_done, w_done_next;
  logic              w_trig_rise;
  logic [DATA_W-1:0] w_sample_ext;

`ifdef SENSE_PRETRIG_EN
  logic [AW-1:0]     r_ring_ptr, w_ring_ptr_next;
  logic [CW-1:0]     r_ring_fill, w_ring_fill_next;
  logic [AW-1:0]     r_start_addr, w_start_addr_next;
`endif

  assign w_sample_ext = DATA_W'(bus.sample_in);

  sense_edge_det u_trig_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (bus.trig),
    .o_rise (w_trig_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_dly_cnt    <= '0;
      r_cnt        <= '0;
      r_ptr        <= CAP_BASE;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_done       <= 1'b0;
`ifdef SENSE_PRETRIG_EN
      r_ring_ptr   <= '0;
      r_ring_fill  <= '0;
      r_start_addr <= '0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_dly_cnt    <= w_dly_cnt_next;
      r_cnt        <= w_cnt_next;
      r_ptr        <= w_ptr_next;
      r_we         <= w_we_next;
      r_waddr      <= w_waddr_next;
      r_wdata      <= w_wdata_next;
      r_done       <= w_done_next;
`ifdef SENSE_PRETRIG_EN
      r_ring_ptr   <= w_ring_ptr_next;
      r_ring_fill  <= w_ring_fill_next;
      r_start_addr <= w_start_addr_next;
`endif
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_dly_cnt_next    = r_dly_cnt;
    w_cnt_next        = r_cnt;
    w_ptr_next        = r_ptr;
    w_we_next         = 1'b0;
    w_waddr_next      = r_waddr;
    w_wdata_next      = r_wdata;
    w_done_next       = 1'b0;
`ifdef SENSE_PRETRIG_EN
    w_ring_ptr_next   = r_ring_ptr;
    w_ring_fill_next  = r_ring_fill;
    w_start_addr_next = r_start_addr;
`endif

    if (bus.arm) begin
      // Arm restarts from any state and takes priority over a trigger edge
      // or a sample in the same cycle; any write in flight is dropped.
      w_state_next      = ST_ARMED;
      w_dly_cnt_next    = '0;
      w_cnt_next        = '0;
      w_ptr_next        = CAP_BASE;
`ifdef SENSE_PRETRIG_EN
      w_ring_ptr_next   = '0;
      w_ring_fill_next  = '0;
      w_start_addr_next = '0;
`endif
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_trig_rise) begin
            w_dly_cnt_next = '0;
            w_state_next   = (bus.trig_delay == '0) ? ST_CAPTURE : ST_DELAY;
`ifdef SENSE_PRETRIG_EN
            // Once the ring has wrapped, the slot about to be overwritten
            // next holds the oldest sample.
            w_start_addr_next = (r_ring_fill == RING_FULL) ? r_ring_ptr : '0;
`endif
          end
`ifdef SENSE_PRETRIG_EN
          // The sample arriving with the trigger edge is not kept in the ring.
          else if (bus.sample_valid) begin
            w_we_next       = 1'b1;
            w_waddr_next    = r_ring_ptr;
            w_wdata_next    = w_sample_ext;
            w_ring_ptr_next = (r_ring_ptr == RING_LAST) ? '0 : r_ring_ptr + AW'(1);
            if (r_ring_fill != RING_FULL) begin
              w_ring_fill_next = r_ring_fill + CW'(1);
            end
          end
`endif
        end

        ST_DELAY: begin
          // Counts clock cycles, samples are ignored. trig_delay is expected
          // to stay stable for the duration of an acquisition.
          if (r_dly_cnt == (bus.trig_delay - DLYW'(1))) begin
            w_state_next = ST_CAPTURE;
          end else begin
            w_dly_cnt_next = r_dly_cnt + DLYW'(1);
          end
        end

        ST_CAPTURE: begin
          if (bus.sample_valid) begin
            w_we_next    = 1'b1;
            w_waddr_next = r_ptr;
            w_wdata_next = w_sample_ext;
            w_ptr_next   = r_ptr + AW'(1);
            w_cnt_next   = r_cnt + CW'(1);
            // Leaving CAPTURE on the last accept makes done rise one cycle
            // after the final write, with we already low.
            if (r_cnt == LAST_CNT) begin
              w_state_next = ST_DONE;
            end
          end
        end

        ST_DONE: begin
          w_done_next = 1'b1;
        end

        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  assign bus.we     = r_we;
  assign bus.waddr  = r_waddr;
  assign bus.wdata  = r_wdata;
  assign bus.busy   = state_is_busy(r_state);
  assign bus.done   = r_done;
`ifdef SENSE_PRETRIG_EN
  assign bus.start_addr = r_start_addr;
`else
  assign bus.start_addr = '0;
`endif

endmodule

// File: tb/tb_sense_trace_writer.sv
// -----------------------------------------------------------------------------
// tb_sense_trace_writer
//   Drives directed and randomized acquisitions into sense_trace_writer,
//   records every cycle's inputs and outputs, and compares them against
//   expectations derived per acquisition from the arm/trigger/sample rules.
//   Honours SENSE_PRETRIG_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_sense_trace_writer;
  import sense_trace_writer_pkg::*;

  localparam int AW      = DEF_AW;
  localparam int SW      = DEF_SW;
  localparam int NSAMP   = DEF_NSAMP;
  localparam int DLYW    = DEF_DLYW;
  localparam int PRETRIG = DEF_PRETRIG;
  localparam int MAXC    = 4096;
`ifdef SENSE_PRETRIG_EN
  localparam int CAP_BASE = PRETRIG;
`else
  localparam int CAP_BASE = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sense_trace_writer_if #(.AW(AW), .SW(SW), .DLYW(DLYW)) bus ();

  sense_trace_writer #(
    .AW(AW), .SW(SW), .NSAMP(NSAMP), .DLYW(DLYW), .PRETRIG(PRETRIG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int seg_lo;
  int cur_dly = 0;
  bit trig_lvl = 1'b0;

  // Per-cycle record: in_*[i] is what the DUT sampled at edge i,
  // obs_*[i] is what it showed just after edge i.
  bit            in_arm  [MAXC];
  bit            in_trig [MAXC];
  bit            in_sv   [MAXC];
  logic [SW-1:0] in_smp  [MAXC];
  int            in_dly  [MAXC];
  logic          obs_we   [MAXC];
  logic          obs_done [MAXC];
  logic          obs_busy [MAXC];
  logic [AW-1:0] obs_waddr[MAXC];
  logic [AW-1:0] obs_start[MAXC];
  logic [7:0]    obs_wdata[MAXC];
  bit            exp_we   [MAXC];
  bit            exp_done [MAXC];
  bit            exp_busy [MAXC];
  int            exp_waddr[MAXC];
  int            exp_wdata[MAXC];
  int            exp_start[MAXC];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit arm, input bit sv, input logic [SW-1:0] smp);
    if (cyc >= MAXC - 2) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC - 2);
      $fatal(1, "cycle budget exhausted");
    end
    bus.arm          = arm;
    bus.trig         = trig_lvl;
    bus.sample_valid = sv;
    bus.sample_in    = smp;
    bus.trig_delay   = DLYW'(cur_dly);
    @(posedge clk);
    cyc++;
    in_arm[cyc]  = arm;
    in_trig[cyc] = trig_lvl;
    in_sv[cyc]   = sv;
    in_smp[cyc]  = smp;
    in_dly[cyc]  = cur_dly;
    #1;
    obs_we[cyc]    = bus.we;
    obs_waddr[cyc] = bus.waddr;
    obs_wdata[cyc] = bus.wdata;
    obs_done[cyc]  = bus.done;
    obs_busy[cyc]  = bus.busy;
    obs_start[cyc] = bus.start_addr;
  endtask

  // Build expectations acquisition by acquisition: an acquisition runs from
  // an arm to the next arm; the first trig rising edge after the arm starts
  // the capture trig_delay cycles later; the first NSAMP valid samples from
  // then on appear as writes in the same recorded cycle.
  task automatic check_segment(input int lo, input int hi);
    int a, nxt, t, k, n, last, start, busy_end;
`ifdef SENSE_PRETRIG_EN
    int n_ring, ring_end;
`endif
    for (int i = lo; i <= hi; i++) begin
      exp_we[i] = 0; exp_done[i] = 0; exp_busy[i] = 0;
      exp_waddr[i] = 0; exp_wdata[i] = 0; exp_start[i] = 0;
    end
    a = lo;
    while (a <= hi) begin
      if (!in_arm[a]) begin
        a++;
      end else begin
        nxt = a + 1;
        while (nxt <= hi && !in_arm[nxt]) nxt++;
        t = -1;
        for (k = a + 1; k < nxt; k++)
          if (t < 0 && in_trig[k] && !in_trig[k-1]) t = k;
        start = 0;
`ifdef SENSE_PRETRIG_EN
        ring_end = (t < 0) ? nxt : t;
        n_ring = 0;
        for (k = a + 1; k < ring_end; k++) begin
          if (in_sv[k]) begin
            exp_we[k] = 1; exp_waddr[k] = n_ring % PRETRIG; exp_wdata[k] = int'(in_smp[k]);
            n_ring++;
          end
        end
        if (n_ring >= PRETRIG) start = n_ring % PRETRIG;
`endif
        last = -1;
        if (t >= 0) begin
          for (k = t; k < nxt; k++) exp_start[k] = start;
          n = 0;
          for (k = t + in_dly[t] + 1; k < nxt && n < NSAMP; k++) begin
            if (in_sv[k]) begin
              exp_we[k] = 1;
              exp_waddr[k] = (CAP_BASE + n) % (1 << AW);
              exp_wdata[k] = int'(in_smp[k]);
              n++;
              if (n == NSAMP) last = k;
            end
          end
        end
        busy_end = (last >= 0) ? last - 1 : nxt - 1;
        for (k = a; k <= busy_end && k <= hi; k++) exp_busy[k] = 1;
        if (last >= 0) for (k = last + 1; k < nxt && k <= hi; k++) exp_done[k] = 1;
        a = nxt;
      end
    end
    for (int i = lo; i <= hi; i++) begin
      check_val($sformatf("we@%0d", i), 32'(obs_we[i]), 32'(exp_we[i]));
      if (exp_we[i]) begin
        check_val($sformatf("waddr@%0d", i), 32'(obs_waddr[i]), exp_waddr[i]);
        check_val($sformatf("wdata@%0d", i), 32'(obs_wdata[i]), exp_wdata[i]);
      end
      check_val($sformatf("done@%0d", i), 32'(obs_done[i]), 32'(exp_done[i]));
      check_val($sformatf("busy@%0d", i), 32'(obs_busy[i]), 32'(exp_busy[i]));
      if (exp_done[i])
        check_val($sformatf("start_addr@%0d", i), 32'(obs_start[i]), exp_start[i]);
    end
  endtask

  initial begin
    int p;
    bus.arm = 1'b0; bus.trig = 1'b0; bus.sample_valid = 1'b0;
    bus.sample_in = '0; bus.trig_delay = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_we",    32'(bus.we), 0);
    check_val("rst_waddr", 32'(bus.waddr), 0);
    check_val("rst_wdata", 32'(bus.wdata), 0);
    check_val("rst_busy",  32'(bus.busy), 0);
    check_val("rst_done",  32'(bus.done), 0);
    check_val("rst_start", 32'(bus.start_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    seg_lo = 1;

    // Idle with samples: nothing written before arm.
    for (int i = 0; i < 4; i++) step(0, 1, SW'($urandom));

    // Directed: trigger, no delay, continuous samples 0..
    cur_dly = 0; trig_lvl = 0;
    step(1, 0, '0);
    step(0, 0, '0);
    trig_lvl = 1;
    step(0, 1, SW'(127));
    for (int i = 0; i < 62; i++) step(0, 1, SW'(i));
    trig_lvl = 0;
    for (int i = 0; i < 3; i++) step(0, 1, SW'($urandom));

    // Directed: delay 5, samples during delay must not be stored.
    cur_dly = 5;
    step(1, 0, '0);
    step(0, 1, SW'($urandom));
    trig_lvl = 1;
    for (int i = 0; i < 70; i++) step(0, 1, SW'($urandom));

    // Directed: sample_valid alternating.
    cur_dly = 0; trig_lvl = 0;
    step(1, 0, '0);
    trig_lvl = 1;
    step(0, 0, '0);
    for (int i = 0; i < 120; i++) step(0, bit'(i % 2 == 0), SW'($urandom));

    // Directed: trigger already high at arm is not an edge.
    trig_lvl = 1;
    for (int i = 0; i < 3; i++) step(0, 0, '0);
    step(1, 1, SW'($urandom));
    for (int i = 0; i < 10; i++) step(0, 1, SW'($urandom));
    trig_lvl = 0;
    for (int i = 0; i < 2; i++) step(0, 1, SW'($urandom));
    trig_lvl = 1;
    for (int i = 0; i < 62; i++) step(0, 1, SW'($urandom));

    // Directed: abort after 20 writes, restart from the base address.
    trig_lvl = 0;
    step(1, 0, '0);
    trig_lvl = 1;
    step(0, 1, SW'($urandom));
    for (int i = 0; i < 20; i++) step(0, 1, SW'($urandom));
    step(1, 1, SW'($urandom));
    for (int i = 0; i < 3; i++) step(0, 1, SW'($urandom));
    trig_lvl = 0;
    step(0, 1, SW'($urandom));
    trig_lvl = 1;
    for (int i = 0; i < 60; i++) step(0, 1, SW'($urandom));

    // Directed: 11 samples while armed, then trigger (ring case when enabled).
    trig_lvl = 0;
    step(1, 0, '0);
    for (int i = 0; i < 11; i++) step(0, 1, SW'(i));
    trig_lvl = 1;
    step(0, 0, '0);
    for (int i = 0; i < 60; i++) step(0, 1, SW'(i + 11));

    // Asynchronous reset in the middle of a capture.
    trig_lvl = 0;
    step(1, 0, '0);
    trig_lvl = 1;
    step(0, 0, '0);
    for (int i = 0; i < 10; i++) step(0, 1, SW'($urandom));
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_we",   32'(bus.we), 0);
    check_val("async_rst_busy", 32'(bus.busy), 0);
    check_val("async_rst_done", 32'(bus.done), 0);
    check_segment(seg_lo, cyc);
    bus.arm = 1'b0; bus.trig = 1'b0; bus.sample_valid = 1'b0; trig_lvl = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seg_lo = cyc + 1;
    for (int i = 0; i < 3; i++) step(0, 1, SW'($urandom));

    // Randomized acquisitions: random delay, sample density, trigger
    // toggling and occasional re-arm.
    for (int tr = 0; tr < 8; tr++) begin
      cur_dly = $urandom_range(0, 12);
      p = $urandom_range(1, 4);
      step(1, 0, '0);
      for (int c = 0; c < 160; c++) begin
        if ($urandom_range(0, 15) == 0) trig_lvl = ~trig_lvl;
        step(bit'($urandom_range(0, 199) == 0), bit'($urandom_range(0, 3) < p), SW'($urandom));
      end
    end
    for (int i = 0; i < 5; i++) step(0, 1, SW'($urandom));
    check_segment(seg_lo, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
